sram_axi_bridge: RTL and testbench
==================================

Name: sram_axi_bridge

Overview:
Converts the core's two SRAM-like ports (instruction: read-only; data: read/write) into one AXI3 master interface, with single-beat transfers only. Sits directly downstream of mips_cpu and consumes its inst_*/data_* request streams. Returns addr_ok/data_ok handshakes to the core. Each port has at most one transaction outstanding; the two ports may be outstanding concurrently.

Parameters:
INST_ID, 4'd0, ARID used for instruction reads
DATA_ID, 4'd1, ARID/AWID used for data accesses

Ports:
clk  in  1  clock
resetn  in  1  synchronous reset, active-low
inst_req  in  1  instruction read request
inst_addr  in  32  instruction physical address
inst_addr_ok  out  1  instruction request accepted this cycle
inst_rdata  out  32  instruction read data
inst_data_ok  out  1  instruction data valid, one-cycle pulse
data_req  in  1  data request
data_wr  in  1  1 = write, 0 = read
data_wstrb  in  4  write byte strobes
data_addr  in  32  data physical address
data_size  in  3  log2 bytes (0/1/2)
data_wdata  in  32  write data
data_addr_ok  out  1  data request accepted this cycle
data_rdata  out  32  data read result
data_data_ok  out  1  read data / write response done, one-cycle pulse
arid  out  4  AR id
araddr  out  32  AR address
arsize  out  3  AR size
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  R id
rdata  in  32  R data
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  32  AW address
awsize  out  3  AW size
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  32  W data
wstrb  out  4  W strobes
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  B valid
bready  out  1  B ready
(len=0, burst=INCR, wlast=1, lock/cache/prot=0 are tied at the SoC top level.)

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. Every valid, ok and ready output is 0; both channel FSMs go to IDLE; rdata registers are 0.
- Per-channel FSM: IDLE -> ADDR -> RESP -> IDLE.
- addr_ok is combinational.
  - inst_addr_ok = inst_req & inst IDLE & AR free & no competing data read.
  - data_addr_ok = data_req & data IDLE & (data_wr | AR free).
- The request is latched when addr_ok=1. The FSM enters ADDR and drives arvalid/awvalid from registers on the next cycle.
- AR arbitration: AR is free when no channel is in ADDR for a read. If a data read and an inst read are requested in the same cycle, the data read wins and inst_addr_ok stays 0.
- Read ADDR: arvalid is held with stable araddr/arsize/arid until arready is seen; then the FSM goes to RESP.
  - arsize: inst always 3'd2; data reads use data_size.
- Read RESP:
  - rready=1 while either channel is in read RESP.
  - An R beat is routed by rid: INST_ID to the inst channel, DATA_ID to the data channel.
  - On the R handshake, rdata is registered into the channel's rdata output. The next cycle pulses data_ok=1 for exactly one cycle, and the FSM returns to IDLE in that cycle.
  - Registered rdata holds until the next pulse.
- Write ADDR: awvalid and wvalid are asserted together. Each drops independently after its own handshake (aw_done and w_done flags). The FSM enters RESP when both are done, including when both handshake in the same cycle.
- Write RESP: bready=1. On bvalid, data_data_ok pulses one cycle later and the FSM returns to IDLE.
- addr_ok is never asserted for a channel outside IDLE. A new request is therefore accepted no earlier than the cycle after that channel's data_ok.
- No ordering between inst and data channels; data reads and writes are ordered by the single-outstanding rule.
- R with an unknown rid, or arriving for a channel not in RESP: accepted and discarded, with no data_ok.
- Reset mid-transaction: outstanding AXI transactions are abandoned. The interconnect shares resetn.

Test Plan:
- Inst read 0x1FC00000, arready=1 at once, R (rid=0, 0x3C08BFAF) 2 cycles later -> inst_addr_ok 1 cycle, arvalid 1 cycle with arsize=2, inst_rdata=0x3C08BFAF, inst_data_ok single pulse.
- Simultaneous inst read 0x100 and data read 0x200 (size 0) -> data wins AR first (arid=1, arsize=0); inst AR follows after the data arready. Out-of-order R (rid=0 before rid=1) -> each data_ok carries its correct value.
- Data write 0x300, wstrb=4'b0011, wdata=0x0000ABCD; awready on cycle 1, wready on cycle 3 -> awvalid drops after cycle 1, wvalid held to cycle 3; bvalid -> data_data_ok one pulse; no second AW.
- Back-to-back: data write then data read to the same address -> data_addr_ok for the read stays 0 until the cycle after the write's data_data_ok.
- arready held 0 for 10 cycles -> araddr/arid stable, arvalid held, no addr_ok on either channel for a further read.
- resetn=0 while the data channel is in RESP -> next cycle all valids/oks are 0 and the FSMs are IDLE; a later bvalid produces no data_ok.

Source files
------------

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge
//   Bridges the core's SRAM-like instruction port (read-only) and data port
//   (read/write) onto a single AXI3 master carrying single-beat transfers.
//   Each port keeps at most one transaction in flight. The two ports may be
//   in flight at the same time and complete in either order.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   inst_*                 instruction request / addr_ok / rdata / data_ok
//   data_*                 data request / addr_ok / rdata / data_ok
//   ar*, r*                shared read address / read data channels
//   aw*, w*, b*            write address / write data / write response
//
// Channel FSM (one instance per port)
//   state  | meaning
//   IDLE   | no request outstanding; addr_ok may be given
//   ADDR   | request latched; AR (or AW+W) being presented on the bus
//   RESP   | waiting for R/B; done_q marks the one-cycle data_ok pulse
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic [31:0] inst_rdata,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic [31:0] data_rdata,
    output logic        data_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,

    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_RESP = 2'd2
    } chan_state_e;

    // instruction channel
    chan_state_e inst_state_q, inst_state_d;
    logic [31:0] inst_addr_q,  inst_addr_d;
    logic        inst_done_q,  inst_done_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;

    // data channel
    chan_state_e data_state_q, data_state_d;
    logic        data_wr_q,    data_wr_d;
    logic [31:0] data_addr_q,  data_addr_d;
    logic [2:0]  data_size_q,  data_size_d;
    logic [3:0]  data_wstrb_q, data_wstrb_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic        aw_done_q,    aw_done_d;
    logic        w_done_q,     w_done_d;
    logic        data_done_q,  data_done_d;
    logic [31:0] data_rdata_q, data_rdata_d;

    logic inst_ar;
    logic data_ar;
    logic ar_free;
    logic data_rd_cand;
    logic inst_rwait;
    logic data_rwait;
    logic r_hs;
    logic inst_r_hit;
    logic data_r_hit;
    logic aw_hs;
    logic w_hs;

    // ------------------------------------------------------------------
    // AR arbitration and request acceptance
    // ------------------------------------------------------------------
    assign inst_ar = (inst_state_q == S_ADDR);
    assign data_ar = (data_state_q == S_ADDR) && !data_wr_q;
    assign ar_free = !inst_ar && !data_ar;

    // A data read asking in the same cycle takes AR ahead of the inst port.
    assign data_rd_cand = data_req && !data_wr && (data_state_q == S_IDLE);

    // Gated by resetn so a request seen during reset is never acknowledged
    // and then lost when the FSMs are forced back to IDLE.
    assign data_addr_ok = resetn && data_req && (data_state_q == S_IDLE)
                          && (data_wr || ar_free);
    assign inst_addr_ok = resetn && inst_req && (inst_state_q == S_IDLE)
                          && ar_free && !data_rd_cand;

    // Only one channel can be in read ADDR at a time, so a simple mux works.
    assign arvalid = inst_ar || data_ar;
    assign arid    = inst_ar ? INST_ID     : DATA_ID;
    assign araddr  = inst_ar ? inst_addr_q : data_addr_q;
    assign arsize  = inst_ar ? 3'd2        : data_size_q;

    // ------------------------------------------------------------------
    // R routing
    // ------------------------------------------------------------------
    assign rready     = (inst_state_q == S_RESP)
                        || ((data_state_q == S_RESP) && !data_wr_q);
    assign inst_rwait = (inst_state_q == S_RESP) && !inst_done_q;
    assign data_rwait = (data_state_q == S_RESP) && !data_wr_q && !data_done_q;
    assign r_hs       = rvalid && rready;
    // Beats that match no waiting channel are taken and dropped.
    assign inst_r_hit = r_hs && (rid == INST_ID) && inst_rwait;
    assign data_r_hit = r_hs && (rid == DATA_ID) && data_rwait;

    // ------------------------------------------------------------------
    // Write channels
    // ------------------------------------------------------------------
    assign awvalid = (data_state_q == S_ADDR) && data_wr_q && !aw_done_q;
    assign wvalid  = (data_state_q == S_ADDR) && data_wr_q && !w_done_q;
    assign awaddr  = data_addr_q;
    assign awsize  = data_size_q;
    assign wdata   = data_wdata_q;
    assign wstrb   = data_wstrb_q;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign bready  = (data_state_q == S_RESP) && data_wr_q && !data_done_q;

    assign inst_data_ok = inst_done_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_data_ok = data_done_q;
    assign data_rdata   = data_rdata_q;

    // ------------------------------------------------------------------
    // Instruction channel next state
    // ------------------------------------------------------------------
    always_comb begin
        inst_state_d = inst_state_q;
        inst_addr_d  = inst_addr_q;
        inst_done_d  = inst_done_q;
        inst_rdata_d = inst_rdata_q;
        case (inst_state_q)
            S_IDLE: begin
                if (inst_addr_ok) begin
                    inst_addr_d  = inst_addr;
                    inst_state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (arready) begin
                    inst_state_d = S_RESP;
                end
            end
            S_RESP: begin
                // done_q is the data_ok cycle; the channel stays out of
                // IDLE for it so a new request lands one cycle later.
                if (inst_done_q) begin
                    inst_done_d  = 1'b0;
                    inst_state_d = S_IDLE;
                end else if (inst_r_hit) begin
                    inst_done_d  = 1'b1;
                    inst_rdata_d = rdata;
                end
            end
            default: begin
                inst_state_d = S_IDLE;
                inst_done_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Data channel next state
    // ------------------------------------------------------------------
    always_comb begin
        data_state_d = data_state_q;
        data_wr_d    = data_wr_q;
        data_addr_d  = data_addr_q;
        data_size_d  = data_size_q;
        data_wstrb_d = data_wstrb_q;
        data_wdata_d = data_wdata_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        data_done_d  = data_done_q;
        data_rdata_d = data_rdata_q;
        case (data_state_q)
            S_IDLE: begin
                if (data_addr_ok) begin
                    data_wr_d    = data_wr;
                    data_addr_d  = data_addr;
                    data_size_d  = data_size;
                    data_wstrb_d = data_wstrb;
                    data_wdata_d = data_wdata;
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    data_state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (data_wr_q) begin
                    aw_done_d = aw_done_q || aw_hs;
                    w_done_d  = w_done_q || w_hs;
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        data_state_d = S_RESP;
                    end
                end else if (arready && !inst_ar) begin
                    data_state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (data_done_q) begin
                    data_done_d  = 1'b0;
                    data_state_d = S_IDLE;
                end else if (data_wr_q) begin
                    if (bvalid) begin
                        data_done_d = 1'b1;
                    end
                end else if (data_r_hit) begin
                    data_done_d  = 1'b1;
                    data_rdata_d = rdata;
                end
            end
            default: begin
                data_state_d = S_IDLE;
                data_done_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            inst_state_q <= S_IDLE;
            inst_addr_q  <= 32'd0;
            inst_done_q  <= 1'b0;
            inst_rdata_q <= 32'd0;
            data_state_q <= S_IDLE;
            data_wr_q    <= 1'b0;
            data_addr_q  <= 32'd0;
            data_size_q  <= 3'd0;
            data_wstrb_q <= 4'd0;
            data_wdata_q <= 32'd0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            data_done_q  <= 1'b0;
            data_rdata_q <= 32'd0;
        end else begin
            inst_state_q <= inst_state_d;
            inst_addr_q  <= inst_addr_d;
            inst_done_q  <= inst_done_d;
            inst_rdata_q <= inst_rdata_d;
            data_state_q <= data_state_d;
            data_wr_q    <= data_wr_d;
            data_addr_q  <= data_addr_d;
            data_size_q  <= data_size_d;
            data_wstrb_q <= data_wstrb_d;
            data_wdata_q <= data_wdata_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            data_done_q  <= data_done_d;
            data_rdata_q <= data_rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed scenarios followed by a randomized phase. The random phase keeps a
// word-level model: a read-only instruction ROM function, a shadow data memory
// updated when the core's write is accepted, and an AXI slave with its own
// memory updated from the AW/W beats it actually receives.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [2:0]  data_size;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_size(data_size), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // inputs change just after the rising edge, outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_size = 0; data_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    endtask

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'h3C08_BFAF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
    } rd_t;

    // model state
    logic [31:0] dmem_slv [8];
    logic [31:0] dmem_ref [8];
    rd_t         pend_r [$];
    rd_t         e;
    bit          i_busy, i_pend, i_ar_seen;
    logic [31:0] i_addr_m;
    bit          d_busy, d_pend, d_ar_seen, d_aw_seen, d_w_seen, d_wr_m;
    logic [31:0] d_addr_m, d_wdata_m;
    logic [2:0]  d_size_m;
    logic [3:0]  d_strb_m;
    bit          r_drv, b_drv, s_aw_got, s_w_got;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    int          n_inst, n_data;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 0;
        clr_inputs();
        repeat (3) tick();

        // ---------------- reset state ----------------
        inst_req = 1; data_req = 1;
        smp();
        chk("rst_inst_aok", inst_addr_ok, 0);
        chk("rst_data_aok", data_addr_ok, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_bready", bready, 0);
        chk("rst_inst_dok", inst_data_ok, 0);
        chk("rst_data_dok", data_data_ok, 0);
        chk("rst_inst_rdata", inst_rdata, 0);
        chk("rst_data_rdata", data_rdata, 0);
        tick();
        inst_req = 0; data_req = 0; resetn = 1;

        // ---------------- single inst read ----------------
        tick();
        inst_req = 1; inst_addr = 32'h1FC0_0000; arready = 1;
        smp();
        chk("t1_aok", inst_addr_ok, 1);
        chk("t1_arvalid_early", arvalid, 0);
        tick();
        inst_req = 0;
        smp();
        chk("t1_arvalid", arvalid, 1);
        chk("t1_araddr", araddr, 32'h1FC0_0000);
        chk("t1_arsize", arsize, 2);
        chk("t1_arid", arid, 0);
        chk("t1_aok_busy", inst_addr_ok, 0);
        tick();
        arready = 0;
        smp();
        chk("t1_arvalid_once", arvalid, 0);
        chk("t1_rready", rready, 1);
        tick();
        rvalid = 1; rid = 4'd5; rdata = 32'hDEAD_0005;
        smp();
        tick();
        rid = 4'd1; rdata = 32'hDEAD_0001;
        smp();
        chk("t1_junk_inst_dok", inst_data_ok, 0);
        chk("t1_junk_data_dok0", data_data_ok, 0);
        tick();
        rid = 4'd0; rdata = 32'h3C08_BFAF;
        smp();
        chk("t1_junk_data_dok1", data_data_ok, 0);
        chk("t1_junk_inst_rdata", inst_rdata, 0);
        chk("t1_inst_dok_early", inst_data_ok, 0);
        tick();
        rvalid = 0;
        smp();
        chk("t1_inst_dok", inst_data_ok, 1);
        chk("t1_inst_rdata", inst_rdata, 32'h3C08_BFAF);
        chk("t1_data_dok", data_data_ok, 0);
        chk("t1_data_rdata", data_rdata, 0);
        tick();
        smp();
        chk("t1_inst_dok_pulse", inst_data_ok, 0);
        chk("t1_inst_rdata_hold", inst_rdata, 32'h3C08_BFAF);

        // ---------------- simultaneous reads, out-of-order R ----------------
        tick();
        inst_req = 1; inst_addr = 32'h100;
        data_req = 1; data_wr = 0; data_addr = 32'h200; data_size = 0;
        smp();
        chk("t2_data_aok", data_addr_ok, 1);
        chk("t2_inst_aok_lose", inst_addr_ok, 0);
        tick();
        data_req = 0;
        smp();
        chk("t2_arvalid_d", arvalid, 1);
        chk("t2_arid_d", arid, 1);
        chk("t2_arsize_d", arsize, 0);
        chk("t2_araddr_d", araddr, 32'h200);
        chk("t2_inst_aok_arbusy", inst_addr_ok, 0);
        tick();
        arready = 1;
        smp();
        chk("t2_arid_hold", arid, 1);
        chk("t2_inst_aok_hs", inst_addr_ok, 0);
        tick();
        smp();
        chk("t2_inst_aok_after", inst_addr_ok, 1);
        chk("t2_arvalid_gap", arvalid, 0);
        tick();
        inst_req = 0;
        smp();
        chk("t2_arvalid_i", arvalid, 1);
        chk("t2_arid_i", arid, 0);
        chk("t2_araddr_i", araddr, 32'h100);
        chk("t2_arsize_i", arsize, 2);
        tick();
        arready = 0; rvalid = 1; rid = 0; rdata = 32'hAAAA_0100;
        smp();
        chk("t2_rready", rready, 1);
        tick();
        rid = 1; rdata = 32'h5555_0200;
        smp();
        chk("t2_inst_dok", inst_data_ok, 1);
        chk("t2_inst_rdata", inst_rdata, 32'hAAAA_0100);
        chk("t2_data_dok_early", data_data_ok, 0);
        tick();
        rvalid = 0;
        smp();
        chk("t2_data_dok", data_data_ok, 1);
        chk("t2_data_rdata", data_rdata, 32'h5555_0200);
        chk("t2_inst_dok_pulse", inst_data_ok, 0);
        tick();
        smp();
        chk("t2_data_dok_pulse", data_data_ok, 0);

        // ---------------- write with split AW/W handshakes ----------------
        tick();
        data_req = 1; data_wr = 1; data_addr = 32'h300; data_size = 1;
        data_wstrb = 4'b0011; data_wdata = 32'h0000_ABCD; awready = 1; wready = 0;
        smp();
        chk("t3_aok", data_addr_ok, 1);
        tick();
        data_req = 0; data_wdata = 32'hFFFF_FFFF;
        smp();
        chk("t3_awvalid_c1", awvalid, 1);
        chk("t3_wvalid_c1", wvalid, 1);
        chk("t3_awaddr", awaddr, 32'h300);
        chk("t3_awsize", awsize, 1);
        tick();
        awready = 0;
        smp();
        chk("t3_awvalid_c2", awvalid, 0);
        chk("t3_wvalid_c2", wvalid, 1);
        tick();
        wready = 1;
        smp();
        chk("t3_wvalid_c3", wvalid, 1);
        chk("t3_wdata", wdata, 32'h0000_ABCD);
        chk("t3_wstrb", wstrb, 4'b0011);
        chk("t3_awvalid_c3", awvalid, 0);
        tick();
        wready = 0;
        smp();
        chk("t3_wvalid_done", wvalid, 0);
        chk("t3_awvalid_done", awvalid, 0);
        chk("t3_bready", bready, 1);

        // ---------------- read queued behind the write ----------------
        tick();
        bvalid = 1; data_req = 1; data_wr = 0; data_addr = 32'h300; data_size = 2;
        smp();
        chk("t4_aok_resp", data_addr_ok, 0);
        chk("t4_dok_early", data_data_ok, 0);
        tick();
        bvalid = 0;
        smp();
        chk("t4_write_dok", data_data_ok, 1);
        chk("t4_aok_dok_cycle", data_addr_ok, 0);
        chk("t4_no_second_aw", awvalid, 0);
        tick();
        smp();
        chk("t4_write_dok_pulse", data_data_ok, 0);
        chk("t4_aok_after", data_addr_ok, 1);

        // ---------------- AR stall ----------------
        tick();
        data_req = 0; inst_req = 1; inst_addr = 32'h400;
        for (int i = 0; i < 10; i++) begin
            smp();
            chk("t5_arvalid_hold", arvalid, 1);
            chk("t5_araddr_hold", araddr, 32'h300);
            chk("t5_arid_hold", arid, 1);
            chk("t5_inst_aok_stall", inst_addr_ok, 0);
            tick();
        end
        arready = 1;
        smp();
        chk("t5_arvalid_hs", arvalid, 1);
        tick();
        smp();
        chk("t5_inst_aok", inst_addr_ok, 1);
        tick();
        inst_req = 0;
        smp();
        chk("t5_arid_i", arid, 0);
        chk("t5_araddr_i", araddr, 32'h400);
        tick();
        arready = 0; rvalid = 1; rid = 1; rdata = 32'h1234_ABCD;
        smp();
        tick();
        rid = 0; rdata = 32'h0BAD_0400;
        smp();
        chk("t5_data_dok", data_data_ok, 1);
        chk("t5_data_rdata", data_rdata, 32'h1234_ABCD);
        tick();
        rvalid = 0;
        smp();
        chk("t5_inst_dok", inst_data_ok, 1);
        chk("t5_inst_rdata", inst_rdata, 32'h0BAD_0400);

        // ---------------- reset during write RESP ----------------
        tick();
        data_req = 1; data_wr = 1; data_addr = 32'h500; data_wstrb = 4'hF;
        data_wdata = 32'h600D_0500; awready = 1; wready = 1;
        smp();
        chk("t6_aok", data_addr_ok, 1);
        tick();
        data_req = 0;
        smp();
        chk("t6_awvalid", awvalid, 1);
        chk("t6_wvalid", wvalid, 1);
        tick();
        smp();
        chk("t6_bready", bready, 1);
        chk("t6_awvalid_drop", awvalid, 0);
        chk("t6_wvalid_drop", wvalid, 0);
        tick();
        resetn = 0;
        smp();
        tick();
        resetn = 1; awready = 0; wready = 0;
        smp();
        chk("t6_bready_rst", bready, 0);
        chk("t6_arvalid_rst", arvalid, 0);
        chk("t6_awvalid_rst", awvalid, 0);
        chk("t6_wvalid_rst", wvalid, 0);
        chk("t6_rready_rst", rready, 0);
        chk("t6_data_dok_rst", data_data_ok, 0);
        chk("t6_inst_dok_rst", inst_data_ok, 0);
        chk("t6_data_rdata_rst", data_rdata, 0);
        chk("t6_inst_rdata_rst", inst_rdata, 0);
        tick();
        bvalid = 1;
        smp();
        chk("t6_bready_late", bready, 0);
        tick();
        bvalid = 0;
        smp();
        chk("t6_late_b_dok", data_data_ok, 0);
        tick();
        smp();
        chk("t6_late_b_dok2", data_data_ok, 0);

        // ---------------- randomized traffic ----------------
        clr_inputs();
        for (int k = 0; k < 8; k++) begin
            dmem_slv[k] = $urandom;
            dmem_ref[k] = dmem_slv[k];
        end
        i_busy = 0; i_pend = 0; i_ar_seen = 0;
        d_busy = 0; d_pend = 0; d_ar_seen = 0; d_aw_seen = 0; d_w_seen = 0;
        r_drv = 0; b_drv = 0; s_aw_got = 0; s_w_got = 0;
        n_inst = 0; n_data = 0;

        for (int c = 0; c < 2400; c++) begin
            if (c >= 2000 && !i_busy && !i_pend && !d_busy && !d_pend) break;
            tick();
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            if (!r_drv && pend_r.size() > 0 && $urandom_range(0, 2) == 0) begin
                int idx;
                idx = $urandom_range(0, pend_r.size() - 1);
                e = pend_r[idx];
                pend_r.delete(idx);
                rid   = e.id;
                rdata = (e.id == 4'd0) ? rom(e.addr) : dmem_slv[e.addr[4:2]];
                r_drv = 1;
            end
            if (s_aw_got && s_w_got && !b_drv && $urandom_range(0, 1) == 1) begin
                dmem_slv[s_awaddr[4:2]] = merge(dmem_slv[s_awaddr[4:2]], s_wdata, s_wstrb);
                s_aw_got = 0; s_w_got = 0; b_drv = 1;
            end
            rvalid = r_drv;
            bvalid = b_drv;
            if (c < 2000 && !i_busy && !i_pend && $urandom_range(0, 1) == 1) begin
                inst_addr = 32'h1FC0_0000 + 32'($urandom_range(0, 15)) * 4;
                i_pend = 1;
            end
            if (c < 2000 && !d_busy && !d_pend && $urandom_range(0, 1) == 1) begin
                data_wr    = 1'($urandom_range(0, 1));
                data_addr  = 32'h200 + 32'($urandom_range(0, 7)) * 4;
                data_size  = 3'($urandom_range(0, 2));
                data_wstrb = 4'($urandom_range(1, 15));
                data_wdata = $urandom;
                d_pend = 1;
            end
            inst_req = i_pend;
            data_req = d_pend;
            smp();

            if (arvalid && arready) begin
                if (arid == 4'd0) begin
                    chk("r_ar_inst_expected", i_busy && !i_ar_seen, 1);
                    chk("r_ar_inst_addr", araddr, i_addr_m);
                    chk("r_ar_inst_size", arsize, 2);
                    i_ar_seen = 1;
                end else begin
                    chk("r_ar_id", arid, 1);
                    chk("r_ar_data_expected", d_busy && !d_wr_m && !d_ar_seen, 1);
                    chk("r_ar_data_addr", araddr, d_addr_m);
                    chk("r_ar_data_size", arsize, d_size_m);
                    d_ar_seen = 1;
                end
                e.id = arid; e.addr = araddr;
                pend_r.push_back(e);
            end
            if (awvalid && awready) begin
                chk("r_aw_expected", d_busy && d_wr_m && !d_aw_seen, 1);
                chk("r_awaddr", awaddr, d_addr_m);
                chk("r_awsize", awsize, d_size_m);
                d_aw_seen = 1; s_aw_got = 1; s_awaddr = awaddr;
            end
            if (wvalid && wready) begin
                chk("r_w_expected", d_busy && d_wr_m && !d_w_seen, 1);
                chk("r_wdata", wdata, d_wdata_m);
                chk("r_wstrb", wstrb, d_strb_m);
                d_w_seen = 1; s_w_got = 1; s_wdata = wdata; s_wstrb = wstrb;
            end
            if (rvalid && rready) r_drv = 0;
            if (bvalid && bready) b_drv = 0;
            if (inst_data_ok) begin
                chk("r_inst_dok_expected", i_busy && i_ar_seen, 1);
                chk("r_inst_rdata", inst_rdata, rom(i_addr_m));
                i_busy = 0;
                n_inst++;
            end
            if (data_data_ok) begin
                chk("r_data_dok_expected", d_busy && (d_wr_m ? (d_aw_seen && d_w_seen) : d_ar_seen), 1);
                if (!d_wr_m) chk("r_data_rdata", data_rdata, dmem_ref[d_addr_m[4:2]]);
                d_busy = 0;
                n_data++;
            end
            if (inst_req && inst_addr_ok) begin
                i_pend = 0; i_busy = 1; i_ar_seen = 0; i_addr_m = inst_addr;
            end
            if (data_req && data_addr_ok) begin
                d_pend = 0; d_busy = 1; d_ar_seen = 0; d_aw_seen = 0; d_w_seen = 0;
                d_wr_m = data_wr; d_addr_m = data_addr; d_size_m = data_size;
                d_strb_m = data_wstrb; d_wdata_m = data_wdata;
                if (data_wr)
                    dmem_ref[data_addr[4:2]] = merge(dmem_ref[data_addr[4:2]], data_wdata, data_wstrb);
            end
        end
        chk("r_drain_idle", {i_busy, i_pend, d_busy, d_pend}, 0);
        chk("r_inst_traffic", n_inst > 50, 1);
        chk("r_data_traffic", n_data > 50, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
